// File: rtl/idle_timeout_if.sv
// idle_timeout_if: control inputs, threshold digits and external BCD seconds-counter
// signals shared between idle_timeout_ctrl (slave) and its environment (master).
interface idle_timeout_if;
  logic       ctrl_en;
  logic       activity;
  logic       timeout_ack;
  logic [2:0] thr_tens;
  logic [3:0] thr_units;
  logic [2:0] tens_val;
  logic [3:0] units_val;
  logic       units_en;
  logic       tens_en;
  logic       cnt_load;
  logic       idle_timeout;
  logic       idle_warn;
  logic [1:0] state;
  modport master (
    output ctrl_en, activity, timeout_ack, thr_tens, thr_units, tens_val, units_val,
    input  units_en, tens_en, cnt_load, idle_timeout, idle_warn, state
  );
  modport slave (
    input  ctrl_en, activity, timeout_ack, thr_tens, thr_units, tens_val, units_val,
    output units_en, tens_en, cnt_load, idle_timeout, idle_warn, state
  );
endinterface

// File: rtl/idle_timeout_ctrl.sv
// idle_timeout_ctrl: idle-timer FSM steering external BCD seconds counters; flags idle_timeout at threshold.
// Pre-timeout warning on idle_warn is built only when IDLE_TIMEOUT_WARN_EN is defined.
module idle_timeout_ctrl (
  input logic           clk,
  input logic           rst_n,
  idle_timeout_if.slave bus
);
  typedef enum logic [1:0] {OFF = 2'b00, CLEAR = 2'b01, COUNT = 2'b10, TIMEOUT = 2'b11} state_e;
  state_e     state_q, state_d;
  logic [6:0] thr_q, thr_d;
  logic       idle_timeout_q;
  logic       thr_bad, match;
  assign thr_bad = bus.thr_units > 4'd9 || bus.thr_tens > 3'd5;
  assign thr_d   = state_q == CLEAR ? (thr_bad ? {3'd5, 4'd9} : {bus.thr_tens, bus.thr_units}) : thr_q;
  assign match   = {bus.tens_val, bus.units_val} == thr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q        <= OFF;
      thr_q          <= '0;
      idle_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      thr_q          <= thr_d;
      idle_timeout_q <= state_d == TIMEOUT;
    end
  // ctrl_en=0 overrides every transition; activity beats a match in COUNT
  always_comb
    state_d = !bus.ctrl_en       ? OFF :
              state_q == OFF     ? CLEAR :
              state_q == CLEAR   ? (bus.activity ? CLEAR : COUNT) :
              state_q == COUNT   ? (bus.activity ? CLEAR : (match ? TIMEOUT : COUNT)) :
              (bus.timeout_ack || bus.activity) ? CLEAR : TIMEOUT;
  always_comb begin
    bus.units_en = state_q == COUNT && !bus.activity && !match;
    bus.tens_en  = bus.units_en && bus.units_val == 4'd9;
    bus.cnt_load = state_q == CLEAR;
  end
  assign bus.state        = state_q;
  assign bus.idle_timeout = idle_timeout_q;
`ifdef IDLE_TIMEOUT_WARN_EN
  logic       idle_warn_q, idle_warn_d;
  logic [6:0] elapsed, thr_s, warn_lim, elapsed_nxt;
  assign elapsed     = 7'(bus.tens_val) * 7'd10 + 7'(bus.units_val);
  assign thr_s       = 7'(thr_q[6:4]) * 7'd10 + 7'(thr_q[3:0]);
  assign warn_lim    = thr_s > 7'd5 ? thr_s - 7'd5 : 7'd0;
  // counters read zero on the first COUNT cycle after CLEAR, otherwise advance by one
  assign elapsed_nxt = state_q == COUNT ? elapsed + 7'd1 : 7'd0;
  assign idle_warn_d = state_d == COUNT && elapsed_nxt >= warn_lim;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_warn_q <= 1'b0;
    else idle_warn_q <= idle_warn_d;
  assign bus.idle_warn = idle_warn_q;
`else
  assign bus.idle_warn = 1'b0;
`endif
endmodule

// File: tb/tb_idle_timeout_ctrl.sv
`timescale 1ns/1ps
// tb_idle_timeout_ctrl: directed scoreboard bench for idle_timeout_ctrl; models the two
// external BCD seconds counters and checks state, strobes, flag and counter values per cycle.
module tb_idle_timeout_ctrl;
  localparam logic [1:0]  OFF = 2'd0, CLR = 2'd1, CNT = 2'd2, TMO = 2'd3;
  localparam logic [13:0] ALL = 14'h3fff, NOCNT = 14'h3f80;
  typedef struct {string tag; logic [13:0] v; logic [13:0] m;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, te_pulses = 0;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [3:0] units_q;
  logic [2:0] tens_q;
  idle_timeout_if bus();
  idle_timeout_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.units_val = units_q;
  assign bus.tens_val  = tens_q;
  // external counters: synchronous load to 0, BCD wrap 9->0 and 5->0
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      units_q <= 4'd0;
      tens_q  <= 3'd0;
    end else if (bus.cnt_load) begin
      units_q <= 4'd0;
      tens_q  <= 3'd0;
    end else begin
      if (bus.units_en) units_q <= units_q == 4'd9 ? 4'd0 : units_q + 4'd1;
      if (bus.tens_en) tens_q <= tens_q == 3'd5 ? 3'd0 : tens_q + 3'd1;
    end
  function automatic logic [13:0] pk(input logic [1:0] st, input logic to, input logic ue, input logic te,
                                     input logic ld, input logic [2:0] t, input logic [3:0] u);
    return {st, to, ue, te, ld, 1'b0, t, u};
  endfunction
  function automatic logic [13:0] obs();
    return {bus.state, bus.idle_timeout, bus.units_en, bus.tens_en, bus.cnt_load, bus.idle_warn,
            bus.tens_val, bus.units_val};
  endfunction
  task automatic push(input string tag, input logic [13:0] v, input logic [13:0] m);
    exp_t e;
    e.tag = tag;
    e.v = v;
    e.m = m;
    sb.push_back(e);
  endtask
  task automatic check_val(input logic [13:0] o);
    exp_t e;
    e = sb.pop_front();
    vectors++;
    assert ((o & e.m) === (e.v & e.m))
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", e.tag, o & e.m, e.v & e.m);
    end
  endtask
  // tens_en is sampled mid-cycle, where it is stable for the coming edge
  task automatic tick();
    @(negedge clk);
    if (bus.tens_en) te_pulses++;
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag, input logic [13:0] v, input logic [13:0] m = ALL);
    push(tag, v, m);
    tick();
    check_val(obs());
  endtask
  task automatic run_to(input string tag, input int from, input int n);
    for (int s = from; s <= n; s++)
      step(tag, pk(CNT, 1'b0, 1'(s != n), 1'(s % 10 == 9 && s != n), 1'b0, 3'(s / 10), 4'(s % 10)));
    step({tag, "_tmo"}, pk(TMO, 1'b1, 1'b0, 1'b0, 1'b0, 3'(n / 10), 4'(n % 10)));
  endtask
  initial begin
    bus.ctrl_en = 1'b0; bus.activity = 1'b0; bus.timeout_ack = 1'b0;
    bus.thr_tens = 3'd0; bus.thr_units = 4'd5;
    #1 rst_n = 1'b0;
    #2;
    push("rst", pk(OFF, 0, 0, 0, 0, 0, 0), ALL);
    check_val(obs());
    step("rst_hold", pk(OFF, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step("rst_rel_off", pk(OFF, 0, 0, 0, 0, 0, 0));
    bus.ctrl_en = 1'b1;
    step("a_clear", pk(CLR, 0, 0, 0, 1, 0, 0));
    run_to("a", 0, 5);
    step("a_hold", pk(TMO, 1, 0, 0, 0, 0, 5));
    bus.timeout_ack = 1'b1;
    step("a_ack", pk(CLR, 0, 0, 0, 1, 0, 5));
    bus.timeout_ack = 1'b0;
    for (int i = 0; i < 4; i++) step("b_count", pk(CNT, 0, 1, 0, 0, 0, 4'(i)));
    bus.activity = 1'b1;
    step("b_act", pk(CLR, 0, 0, 0, 1, 0, 0), NOCNT);
    step("b_act_hold", pk(CLR, 0, 0, 0, 1, 0, 0));
    bus.activity = 1'b0;
    run_to("b", 0, 5);
    bus.activity = 1'b1;
    step("b_tmo_act", pk(CLR, 0, 0, 0, 1, 0, 5));
    bus.activity = 1'b0;
    run_to("b2", 0, 5);
    bus.timeout_ack = 1'b1; bus.ctrl_en = 1'b0;
    step("ack_off", pk(OFF, 0, 0, 0, 0, 0, 5));
    bus.timeout_ack = 1'b0; bus.ctrl_en = 1'b1;
    bus.thr_tens = 3'd1; bus.thr_units = 4'd2;
    step("c_clear", pk(CLR, 0, 0, 0, 1, 0, 5));
    te_pulses = 0;
    run_to("c", 0, 12);
    push("c_te_once", 14'd1, ALL);
    check_val(14'(te_pulses));
    bus.thr_tens = 3'd7; bus.thr_units = 4'd9; bus.timeout_ack = 1'b1;
    step("d_clear", pk(CLR, 0, 0, 0, 1, 1, 2));
    bus.timeout_ack = 1'b0;
    step("d_count", pk(CNT, 0, 1, 0, 0, 0, 0));
    bus.thr_tens = 3'd0; bus.thr_units = 4'd1;
    run_to("d", 1, 59);
    bus.thr_tens = 3'd0; bus.thr_units = 4'd0; bus.timeout_ack = 1'b1;
    step("e_clear", pk(CLR, 0, 0, 0, 1, 5, 9));
    bus.timeout_ack = 1'b0;
    run_to("e", 0, 0);
    bus.thr_tens = 3'd0; bus.thr_units = 4'd5; bus.timeout_ack = 1'b1;
    step("f_clear", pk(CLR, 0, 0, 0, 1, 0, 0));
    bus.timeout_ack = 1'b0;
    for (int i = 0; i < 3; i++) step("f_count", pk(CNT, 0, 1, 0, 0, 0, 4'(i)));
    #2 rst_n = 1'b0;
    #1;
    push("f_rst_async", pk(OFF, 0, 0, 0, 0, 0, 0), ALL);
    check_val(obs());
    step("f_rst_hold", pk(OFF, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step("f_rst_leave", pk(CLR, 0, 0, 0, 1, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
